// File: rtl/fetch_queue_if.sv
// fetch_queue handshake bundle.
// master = IF/ID side, slave = the queue.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] push_pc;
  logic [XLEN-1:0] push_instruction;
  logic [XLEN-1:0] push_imm;
  logic            push_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_imm;
  logic            out_pred_taken;

  modport master (
    output push_valid,
    output push_pc,
    output push_instruction,
    output push_imm,
    output push_pred_taken,
    output out_ready,
    input  push_ready,
    input  out_valid,
    input  out_pc,
    input  out_instruction,
    input  out_imm,
    input  out_pred_taken
  );

  modport slave (
    input  push_valid,
    input  push_pc,
    input  push_instruction,
    input  push_imm,
    input  push_pred_taken,
    input  out_ready,
    output push_ready,
    output out_valid,
    output out_pc,
    output out_instruction,
    output out_imm,
    output out_pred_taken
  );
endinterface

// File: rtl/fetch_queue.sv
// IF->ID decoupling FIFO: pc, instruction,
// imm and prediction per entry; 1-cycle flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  fetch_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push_ready;
  logic            out_valid;
  logic            push_en;
  logic            pop_en;

  assign push_ready = (count != CW'(DEPTH));
  assign out_valid  = (count != '0);

  assign push_en = bus.push_valid & push_ready & ~flush;
  assign pop_en  = bus.out_ready & out_valid & ~flush;

  assign wr_entry = '{
    pc:          bus.push_pc,
    instruction: bus.push_instruction,
    imm:         bus.push_imm,
    pred_taken:  bus.push_pred_taken
  };

  assign head = mem[rd_ptr];

  assign bus.push_ready      = push_ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_pc          = head.pc;
  assign bus.out_instruction = head.instruction;
  assign bus.out_imm         = head.imm;
  assign bus.out_pred_taken  = head.pred_taken;

  // occupancy next-state: push/pop balance
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push_en & ~pop_en: count_nxt = count + CW'(1);
      ~push_en & pop_en: count_nxt = count - CW'(1);
      default:           count_nxt = count;
    endcase
  end

  // pointers and count; flush empties at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // entry storage; cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end
endmodule
